spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Command sequencer behind the SPI slave byte interface, which runs SPI mode 3 on a 62.5 MHz system clock. Parses the MOSI byte stream of each slave-select frame into read/write register transactions against an internal 16x8 register bank. Presents the MISO response byte for every byte slot, and mirrors register writes to fabric logic. Also drives LED1 from a register bit.

## Interface
- ID_VALUE, 8'h5A: constant returned from register 15 and in the command-byte slot.
- CLOCK_Y2  in  1  system clock, 62.5 MHz.
- RESET  in  1  asynchronous, active-high reset.
- frame_active  in  1  synchronized slave-select, high while SS is low.
- rx_valid  in  1  one-cycle pulse, a complete MOSI byte is on rx_data.
- rx_data  in  8  received byte, valid with rx_valid.
- tx_data  out  8  byte the byte interface shifts out in the next byte slot.
- wr_strobe  out  1  one-cycle pulse on every committed register write.
- wr_addr  out  4  address of the committed write.
- wr_data  out  8  data of the committed write.
- rd_addr  in  4  fabric read address.
- rd_data  out  8  combinational read of the register bank at rd_addr.
- LED1  out  1  reg[0] bit 0.
- err  out  1  sticky, set on a write to a read-only address, cleared only by RESET.

## Operation
- Register bank:
  - reg[0..13] read/write.
  - reg[14] read-only frame counter.
  - reg[15] read-only ID_VALUE.
- Command byte, the first byte of a frame:
  - bit7 = 1 for write, 0 for read.
  - bit6 = auto-increment.
  - bits5:4 ignored.
  - bits3:0 = start address.
- States: IDLE, CMD, WR, RD.
- IDLE:
  - Moves to CMD when frame_active is high.
  - tx_data = ID_VALUE.
- CMD: on rx_valid, latch addr and auto-increment, then:
  - If write: go to WR.
  - If read: go to RD and load tx_data = reg[addr].
- WR: on each rx_valid:
  - If addr < 14: reg[addr] <= rx_data, with a one-cycle wr_strobe and wr_addr/wr_data.
  - If addr is 14 or 15: no write, no strobe, err <= 1.
  - Then, if auto-increment is set, addr <= addr+1, wrapping 15 -> 0.
  - tx_data = the byte just written, as an echo. For a read-only address the echo is still rx_data.
- RD: on each rx_valid:
  - If auto-increment is set, addr <= addr+1 (wrapping) and tx_data = reg[new addr].
  - Otherwise tx_data = reg[addr], re-sampled.
  - Incoming data is ignored.
- Any state, when frame_active goes low:
  - Next state is IDLE and tx_data = ID_VALUE.
  - reg[14] increments (8-bit, wraps 255 -> 0) only if at least one rx_valid occurred in the frame.
- rx_valid while in IDLE (frame_active low) is ignored.
- rx_valid and frame_active falling in the same cycle: the byte is processed with normal state semantics first, then the FSM enters IDLE; it counts toward the frame counter.
- Frame ends mid-byte: the partial byte produces no rx_valid, so nothing is committed.
- A write and a fabric read at the same address in the same cycle: rd_data shows the old value; the new value appears from the next cycle.

## Timing
- Reset values:
  - State IDLE.
  - reg[0..14] = 0.
  - tx_data = ID_VALUE.
  - wr_strobe = 0, wr_addr = 0, wr_data = 0.
  - err = 0, LED1 = 0.
- Write latency: the register, wr_strobe and LED1 update on the clock edge after rx_valid (1 cycle).
- tx_data latency: stable no later than 2 cycles after rx_valid.
- Headroom: the byte interface latches tx_data at the first SCK falling edge of the next slot, at least 125 ns ≈ 7 cycles later, so 2 cycles is sufficient.
- Frame-counter latency: the increment is visible 1 cycle after frame_active falls.
- Back-to-back bytes: rx_valid pulses are at least 8 SCK periods apart, so no input buffering is required.

## Test plan
- Write burst:
  - Stimulus: frame with bytes C0 11 22 33 (write, auto-increment, addr 0).
  - Required: reg0 = 11, reg1 = 22, reg2 = 33.
  - Three wr_strobe pulses with wr_addr 0, 1, 2.
  - LED1 = 1; tx_data in the slots is 5A, 11, 22, 33.
- Read burst:
  - Stimulus: after the write burst, frame 40 00 00 00.
  - Required: MISO bytes 5A, 11, 22, 33.
  - No wr_strobe; reg[14] = 2 after the frame ends.
- Wrap and read-only:
  - Stimulus: frame CD AA BB CC DD (write, auto-increment, addr 13).
  - Required: reg13 = AA; addresses 14 and 15 not written; reg0 = DD.
  - err = 1; exactly 2 wr_strobe pulses.
- Non-increment read of ID:
  - Stimulus: frame 0F 00 00.
  - Required: MISO bytes 5A, 5A, 5A; addr stays 15.
- Abort and reset:
  - Stimulus: drop frame_active after 3 SCK edges of the command byte.
  - Required: no strobe, FSM back in IDLE, reg[14] unchanged.
  - Stimulus: then assert RESET mid-write-frame.
  - Required: all registers 0, err = 0, LED1 = 0, tx_data = 5A, reg[14] = 0.
- Simultaneous end:
  - Stimulus: rx_valid for byte 77 coincident with frame_active falling in a C5 frame.
  - Required: reg5 = 77, one strobe, reg[14] increments once.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: turns the MOSI byte stream of each frame into register
// reads/writes on a 16x8 bank, supplies the MISO byte and mirrors writes to fabric.
module spi_reg_ctrl #(
   parameter logic [7:0] ID_VALUE = 8'h5A
) (
   input  logic       CLOCK_Y2,
   input  logic       RESET,
   input  logic       frame_active,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [7:0] tx_data,
   output logic       wr_strobe,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       LED1,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

   state_t     state_q;
   logic [7:0] regs_q [14];
   logic [7:0] frame_cnt_q;
   logic [3:0] addr_q;
   logic       incr_q;
   logic       seen_byte_q;
   logic [7:0] tx_data_q;
   logic       wr_strobe_q;
   logic [3:0] wr_addr_q;
   logic [7:0] wr_data_q;
   logic       err_q;

   logic [7:0] bank [16];
   logic [3:0] addr_d;

   // Flat read view of the whole map: 14 RW registers, frame counter, ID constant.
   for (genvar gi = 0; gi < 14; gi++) begin : g_bank
      assign bank[gi] = regs_q[gi];
   end
   assign bank[14] = frame_cnt_q;
   assign bank[15] = ID_VALUE;

   assign addr_d  = incr_q ? addr_q + 4'd1 : addr_q;
   assign rd_data = bank[rd_addr];

   always_ff @(posedge CLOCK_Y2 or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         for (int i = 0; i < 14; i++) regs_q[i] <= '0;
         frame_cnt_q <= '0;
         addr_q      <= '0;
         incr_q      <= 1'b0;
         seen_byte_q <= 1'b0;
         tx_data_q   <= ID_VALUE;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         wr_strobe_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_data_q   <= ID_VALUE;
               seen_byte_q <= 1'b0;
               if (frame_active) state_q <= CMD;
            end
            CMD: if (rx_valid) begin
               addr_q <= rx_data[3:0];
               incr_q <= rx_data[6];
               if (rx_data[7]) begin
                  state_q <= WR;
               end else begin
                  state_q   <= RD;
                  tx_data_q <= bank[rx_data[3:0]];
               end
            end
            WR: if (rx_valid) begin
               if (addr_q < 4'd14) begin
                  regs_q[addr_q] <= rx_data;
                  wr_strobe_q    <= 1'b1;
                  wr_addr_q      <= addr_q;
                  wr_data_q      <= rx_data;
               end else begin
                  err_q <= 1'b1;
               end
               tx_data_q <= rx_data;
               addr_q    <= addr_d;
            end
            RD: if (rx_valid) begin
               addr_q    <= addr_d;
               tx_data_q <= bank[addr_d];
            end
            default: state_q <= IDLE;
         endcase

         if (state_q != IDLE && rx_valid) seen_byte_q <= 1'b1;

         // Frame end overrides the per-state result; a byte arriving this cycle still counts.
         if (state_q != IDLE && !frame_active) begin
            state_q     <= IDLE;
            tx_data_q   <= ID_VALUE;
            seen_byte_q <= 1'b0;
            if (seen_byte_q || rx_valid) frame_cnt_q <= frame_cnt_q + 8'd1;
         end
      end
   end

   assign tx_data   = tx_data_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign LED1      = regs_q[0][0];
   assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed frames from the test plan plus random frames,
// checked against a register-map model driven by the command-byte rules.
module tb_spi_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       wr_strobe;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       led1;
   logic       err;

   int total = 0;
   int bad   = 0;

   logic [7:0]  m_reg [16];
   logic        m_err;
   logic [11:0] got_wr [$];
   logic [11:0] exp_wr [$];

   spi_reg_ctrl dut (
      .CLOCK_Y2    (clk),
      .RESET       (rst),
      .frame_active(frame_active),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .tx_data     (tx_data),
      .wr_strobe   (wr_strobe),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .LED1        (led1),
      .err         (err)
   );

   always #8 clk = ~clk;

   always @(negedge clk) if (wr_strobe === 1'b1) got_wr.push_back({wr_addr, wr_data});

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
      m_reg[15] = 8'h5A;
      m_err = 1'b0;
   endtask

   task automatic check_bank(input string tag);
      for (int a = 0; a < 16; a++) begin
         rd_addr = a[3:0];
         #1;
         total++;
         if (rd_data !== m_reg[a]) begin
            bad++;
            $display("FAIL %s reg%0d got=%h exp=%h", tag, a, rd_data, m_reg[a]);
         end
      end
      total++;
      if (led1 !== m_reg[0][0]) begin
         bad++;
         $display("FAIL %s led1 got=%b exp=%b", tag, led1, m_reg[0][0]);
      end
      total++;
      if (err !== m_err) begin
         bad++;
         $display("FAIL %s err got=%b exp=%b", tag, err, m_err);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit drop);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      if (drop) frame_active = 1'b0;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   // One frame: model predicts MISO after each byte, strobes and the frame counter.
   task automatic run_frame(input string tag, input logic [7:0] bytes [$], input bit sim_end);
      logic [3:0] a;
      bit         inc;
      bit         wr;
      logic [7:0] exp_tx;
      a = 4'd0; inc = 1'b0; wr = 1'b0; exp_tx = 8'h5A;
      got_wr.delete();
      exp_wr.delete();
      rd_addr = 4'd14;
      @(negedge clk);
      frame_active = 1'b1;
      repeat (4) @(negedge clk);
      foreach (bytes[i]) begin
         bit last;
         last = sim_end && (i == bytes.size() - 1);
         if (i == 0) begin
            a   = bytes[0][3:0];
            inc = bytes[0][6];
            wr  = bytes[0][7];
            exp_tx = wr ? 8'h5A : m_reg[a];
         end else if (wr) begin
            if (a < 4'd14) begin
               m_reg[a] = bytes[i];
               exp_wr.push_back({a, bytes[i]});
            end else begin
               m_err = 1'b1;
            end
            exp_tx = bytes[i];
            if (inc) a = a + 4'd1;
         end else begin
            if (inc) a = a + 4'd1;
            exp_tx = m_reg[a];
         end
         send_byte(bytes[i], last);
         if (!last) begin
            @(negedge clk);
            total++;
            if (tx_data !== exp_tx) begin
               bad++;
               $display("FAIL %s tx byte%0d got=%h exp=%h", tag, i, tx_data, exp_tx);
            end
            repeat (5) @(negedge clk);
         end
      end
      if (!sim_end || bytes.size() == 0) begin
         frame_active = 1'b0;
         @(negedge clk);
      end
      if (bytes.size() > 0) m_reg[14] = m_reg[14] + 8'd1;
      total++;
      if (rd_data !== m_reg[14]) begin
         bad++;
         $display("FAIL %s frame_cnt got=%h exp=%h", tag, rd_data, m_reg[14]);
      end
      total++;
      if (tx_data !== 8'h5A) begin
         bad++;
         $display("FAIL %s idle_tx got=%h exp=5a", tag, tx_data);
      end
      repeat (3) @(negedge clk);
      total++;
      if (got_wr.size() != exp_wr.size()) begin
         bad++;
         $display("FAIL %s strobe_count got=%0d exp=%0d", tag, got_wr.size(), exp_wr.size());
      end else begin
         foreach (exp_wr[k]) begin
            total++;
            if (got_wr[k] !== exp_wr[k]) begin
               bad++;
               $display("FAIL %s strobe%0d got=%h exp=%h", tag, k, got_wr[k], exp_wr[k]);
            end
         end
      end
      $display("frame %s: bytes=%0d strobes=%0d frame_cnt=%0d", tag, bytes.size(), got_wr.size(), m_reg[14]);
   endtask

   task automatic check_reset_outputs(input string tag);
      total++;
      if (tx_data !== 8'h5A) begin bad++; $display("FAIL %s tx got=%h exp=5a", tag, tx_data); end
      total++;
      if (wr_strobe !== 1'b0) begin bad++; $display("FAIL %s wr_strobe got=%b exp=0", tag, wr_strobe); end
      total++;
      if (wr_addr !== 4'h0 || wr_data !== 8'h00) begin
         bad++;
         $display("FAIL %s wr_addr/data got=%h/%h exp=0/00", tag, wr_addr, wr_data);
      end
      check_bank(tag);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      check_reset_outputs("reset");
   endtask

   task automatic test_write_burst();
      logic [7:0] q [$];
      q = '{8'hC0, 8'h11, 8'h22, 8'h33};
      run_frame("write_burst", q, 1'b0);
      check_bank("write_burst");
   endtask

   task automatic test_read_burst();
      logic [7:0] q [$];
      q = '{8'h40, 8'h00, 8'h00, 8'h00};
      run_frame("read_burst", q, 1'b0);
      check_bank("read_burst");
   endtask

   task automatic test_wrap_ro();
      logic [7:0] q [$];
      q = '{8'hCD, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_frame("wrap_ro", q, 1'b0);
      check_bank("wrap_ro");
   endtask

   task automatic test_id_read();
      logic [7:0] q [$];
      q = '{8'h0F, 8'h00, 8'h00};
      run_frame("id_read", q, 1'b0);
      check_bank("id_read");
   endtask

   task automatic test_abort();
      logic [7:0] q [$];
      q = {};
      run_frame("abort", q, 1'b0);
      check_bank("abort");
   endtask

   task automatic test_sim_end();
      logic [7:0] q [$];
      q = '{8'hC5, 8'h77};
      run_frame("sim_end", q, 1'b1);
      check_bank("sim_end");
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      frame_active = 1'b1;
      repeat (3) @(negedge clk);
      send_byte(8'hC3, 1'b0);
      repeat (4) @(negedge clk);
      send_byte(8'h44, 1'b0);
      #3 rst = 1'b1;
      #5;
      frame_active = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      check_reset_outputs("reset_mid");
      $display("frame reset_mid: reset asserted during write frame");
   endtask

   task automatic test_random();
      for (int f = 0; f < 24; f++) begin
         logic [7:0] q [$];
         int         n;
         bit         se;
         n  = $urandom_range(0, 6);
         se = ($urandom_range(0, 3) == 0) && (n > 0);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         run_frame($sformatf("random%0d", f), q, se);
      end
      check_bank("random");
   endtask

   initial begin
      rst          = 1'b0;
      frame_active = 1'b0;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      rd_addr      = 4'h0;
      test_reset();
      test_write_burst();
      test_read_burst();
      test_wrap_ro();
      test_id_read();
      test_abort();
      test_sim_end();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
